// File: rtl/cornice_mobile_if.sv
// Purpose: bundles the frame/motion controls, pixel-under-test coordinates and
//          hit/position results of the cornice_mobile moving-object block.
// Signals (direction seen from the object, i.e. the slave modport):
//   frame_start_i  in   one-cycle pulse at frame start
//   enable_i       in   apply motion on frame_start_i
//   mode_i         in   0 = filled rectangle, 1 = border only
//   dx_i, dy_i     in   signed 8-bit per-frame steps
//   x_controllo_i  in   pixel X under test
//   y_controllo_i  in   pixel Y under test
//   x_pos_o        out  current centre X
//   y_pos_o        out  current centre Y
//   esterno_o      out  pixel inside outer rectangle
//   interno_o      out  pixel inside inner rectangle
//   conferma_o     out  hit according to mode_i
//   rimbalzo_o     out  one-cycle vertical bounce pulse
interface cornice_mobile_if #(
    parameter int unsigned W = 11
);
    logic         frame_start_i;
    logic         enable_i;
    logic         mode_i;
    logic [7:0]   dx_i;
    logic [7:0]   dy_i;
    logic [W-1:0] x_controllo_i;
    logic [W-1:0] y_controllo_i;
    logic [W-1:0] x_pos_o;
    logic [W-1:0] y_pos_o;
    logic         esterno_o;
    logic         interno_o;
    logic         conferma_o;
    logic         rimbalzo_o;

    // Object side
    modport slave (
        input  frame_start_i, enable_i, mode_i, dx_i, dy_i,
        input  x_controllo_i, y_controllo_i,
        output x_pos_o, y_pos_o, esterno_o, interno_o, conferma_o, rimbalzo_o
    );

    // Pipeline/controller side
    modport master (
        output frame_start_i, enable_i, mode_i, dx_i, dy_i,
        output x_controllo_i, y_controllo_i,
        input  x_pos_o, y_pos_o, esterno_o, interno_o, conferma_o, rimbalzo_o
    );
endinterface

// File: rtl/cornice_mobile.sv
// Purpose: moving rectangle/frame object. Keeps its centre position, moves it
//          once per frame (X wraps around the screen, Y bounces off top/bottom)
//          and flags every cycle whether the scanned pixel hits the object.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave modport of cornice_mobile_if (controls, pixel, results)
module cornice_mobile #(
    parameter int unsigned W      = 11,
    parameter int unsigned H_RES  = 1280,
    parameter int unsigned V_RES  = 1024,
    parameter int unsigned LARG   = 100,
    parameter int unsigned ALT    = 100,
    parameter int unsigned SPESS  = 6,
    parameter int unsigned X_INIT = 640,
    parameter int unsigned Y_INIT = 512
) (
    input  logic           clk,
    input  logic           rst,
    cornice_mobile_if.slave bus
);

    // Two guard bits give room for sign plus one overflow bit of the sums.
    localparam int unsigned SW = W + 2;

    localparam logic signed [SW-1:0] H_RES_S  = SW'(H_RES);
    localparam logic signed [SW-1:0] H_HALF_S = SW'(H_RES / 2);
    localparam logic signed [SW-1:0] Y_MIN_S  = SW'(ALT / 2);
    localparam logic signed [SW-1:0] Y_MAX_S  = SW'(V_RES - 1 - ALT / 2);
    localparam logic signed [SW-1:0] OUT_X_S  = SW'(LARG / 2);
    localparam logic signed [SW-1:0] OUT_Y_S  = SW'(ALT / 2);
    localparam logic signed [SW-1:0] IN_X_S   = SW'(LARG / 2 - SPESS);
    localparam logic signed [SW-1:0] IN_Y_S   = SW'(ALT / 2 - SPESS);

    typedef enum logic [1:0] {
        FERMO = 2'd0,
        AGG_X = 2'd1,
        AGG_Y = 2'd2
    } state_t;

    state_t       state_q;
    logic [W-1:0] x_pos_q, x_pos_d;
    logic [W-1:0] y_pos_q, y_pos_d;
    logic         dir_y_q;
    logic         bounce_d;
    logic         esterno_q, esterno_d;
    logic         interno_q, interno_d;
    logic         conferma_q, conferma_d;
    logic         rimbalzo_q;

    logic signed [SW-1:0] x_sum;
    logic signed [SW-1:0] y_sum;
    logic signed [SW-1:0] dy_ext;
    logic signed [SW-1:0] y_step;

    // Next X: add signed step, fold back into [0, H_RES).
    always_comb begin
        x_sum   = SW'(x_pos_q) + {{(SW-8){bus.dx_i[7]}}, bus.dx_i};
        x_pos_d = W'(x_sum);
        if (x_sum[SW-1]) begin
            x_pos_d = W'(x_sum + H_RES_S);
        end else if (x_sum >= H_RES_S) begin
            x_pos_d = W'(x_sum - H_RES_S);
        end
    end

    // Next Y: step in the current direction, clamp to the legal band on a bounce.
    always_comb begin
        dy_ext   = {{(SW-8){bus.dy_i[7]}}, bus.dy_i};
        y_step   = dir_y_q ? dy_ext : -dy_ext;
        y_sum    = SW'(y_pos_q) + y_step;
        y_pos_d  = W'(y_sum);
        bounce_d = 1'b0;
        if (y_sum < Y_MIN_S) begin
            y_pos_d  = W'(Y_MIN_S);
            bounce_d = 1'b1;
        end else if (y_sum > Y_MAX_S) begin
            y_pos_d  = W'(Y_MAX_S);
            bounce_d = 1'b1;
        end
    end

    logic signed [SW-1:0] dx_diff, dy_diff;
    logic signed [SW-1:0] dxa_raw, dxa, dya;

    // Hit test against the registered centre; X distance is circular.
    always_comb begin
        dx_diff = SW'(bus.x_controllo_i) - SW'(x_pos_q);
        dy_diff = SW'(bus.y_controllo_i) - SW'(y_pos_q);
        dxa_raw = dx_diff[SW-1] ? -dx_diff : dx_diff;
        dxa     = (dxa_raw > H_HALF_S) ? (H_RES_S - dxa_raw) : dxa_raw;
        dya     = dy_diff[SW-1] ? -dy_diff : dy_diff;

        esterno_d  = (dxa <= OUT_X_S) && (dya <= OUT_Y_S);
        interno_d  = (dxa <= IN_X_S)  && (dya <= IN_Y_S);
        conferma_d = bus.mode_i ? (esterno_d & ~interno_d) : esterno_d;
    end

    // Motion FSM plus registered hit flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FERMO;
            x_pos_q    <= W'(X_INIT);
            y_pos_q    <= W'(Y_INIT);
            dir_y_q    <= 1'b1;
            esterno_q  <= 1'b0;
            interno_q  <= 1'b0;
            conferma_q <= 1'b0;
            rimbalzo_q <= 1'b0;
        end else begin
            esterno_q  <= esterno_d;
            interno_q  <= interno_d;
            conferma_q <= conferma_d;
            rimbalzo_q <= 1'b0;
            case (state_q)
                FERMO: begin
                    if (bus.frame_start_i && bus.enable_i) begin
                        state_q <= AGG_X;
                    end
                end
                AGG_X: begin
                    x_pos_q <= x_pos_d;
                    state_q <= AGG_Y;
                end
                AGG_Y: begin
                    y_pos_q <= y_pos_d;
                    if (bounce_d) begin
                        dir_y_q    <= ~dir_y_q;
                        rimbalzo_q <= 1'b1;
                    end
                    state_q <= FERMO;
                end
                default: state_q <= FERMO;
            endcase
        end
    end

    assign bus.x_pos_o    = x_pos_q;
    assign bus.y_pos_o    = y_pos_q;
    assign bus.esterno_o  = esterno_q;
    assign bus.interno_o  = interno_q;
    assign bus.conferma_o = conferma_q;
    assign bus.rimbalzo_o = rimbalzo_q;

endmodule

// File: tb/tb_cornice_mobile.sv
// Purpose: directed self-checking bench for cornice_mobile (hit test, X wrap,
//          Y bounce, enable freeze, async reset and ignored frame pulses).
module tb_cornice_mobile;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic rb;

    cornice_mobile_if #(.W(11)) bus ();

    cornice_mobile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full frame update; rb_o captures the bounce pulse in the cycle Y changes.
    task automatic do_frame(input logic [7:0] dxv, input logic [7:0] dyv, output logic rb_o);
        bus.dx_i          = dxv;
        bus.dy_i          = dyv;
        bus.frame_start_i = 1'b1;
        tick();
        bus.frame_start_i = 1'b0;
        tick();
        tick();
        rb_o = bus.rimbalzo_o;
        tick();
    endtask

    task automatic pixel(input int x, input int y);
        bus.x_controllo_i = 11'(x);
        bus.y_controllo_i = 11'(y);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        rst               = 1'b1;
        bus.frame_start_i = 1'b0;
        bus.enable_i      = 1'b1;
        bus.mode_i        = 1'b0;
        bus.dx_i          = 8'd0;
        bus.dy_i          = 8'd0;
        bus.x_controllo_i = 11'd690;
        bus.y_controllo_i = 11'd512;
        tick();
        tick();
        chk("rst_x", 32'(bus.x_pos_o), 640);
        chk("rst_y", 32'(bus.y_pos_o), 512);
        chk("rst_conferma", 32'(bus.conferma_o), 0);
        chk("rst_esterno", 32'(bus.esterno_o), 0);
        chk("rst_rimbalzo", 32'(bus.rimbalzo_o), 0);
        rst = 1'b0;
        tick();

        // Filled mode, right edge inclusive / one past
        bus.mode_i = 1'b0;
        pixel(690, 512);
        chk("fill_edge_hit", 32'(bus.conferma_o), 1);
        pixel(691, 512);
        chk("fill_edge_miss", 32'(bus.conferma_o), 0);
        pixel(640, 562);
        chk("fill_bottom_hit", 32'(bus.esterno_o), 1);
        pixel(640, 563);
        chk("fill_bottom_miss", 32'(bus.esterno_o), 0);

        // Border mode
        bus.mode_i = 1'b1;
        pixel(640, 512);
        chk("border_centre_conf", 32'(bus.conferma_o), 0);
        chk("border_centre_int", 32'(bus.interno_o), 1);
        pixel(688, 512);
        chk("border_band_conf", 32'(bus.conferma_o), 1);
        chk("border_band_est", 32'(bus.esterno_o), 1);
        chk("border_band_int", 32'(bus.interno_o), 0);
        pixel(684, 512);
        chk("border_inner_edge", 32'(bus.conferma_o), 0);
        bus.mode_i = 1'b0;

        // X wrap: 640 -> 1270, +20 -> 10, -30 -> 1260
        for (int i = 0; i < 4; i++) do_frame(8'd127, 8'd0, rb);
        do_frame(8'd122, 8'd0, rb);
        chk("x_1270", 32'(bus.x_pos_o), 1270);
        chk("y_still", 32'(bus.y_pos_o), 512);
        do_frame(8'd20, 8'd0, rb);
        chk("x_wrap_pos", 32'(bus.x_pos_o), 10);
        pixel(1275, 512);
        chk("wrap_hit", 32'(bus.esterno_o), 1);
        pixel(1220, 512);
        chk("wrap_far_miss", 32'(bus.esterno_o), 0);
        do_frame(8'hE2, 8'd0, rb);
        chk("x_wrap_neg", 32'(bus.x_pos_o), 1260);

        // Top bounce: 512 -> 60, then DY=-20 bounces to 50, then moves to 70
        for (int i = 0; i < 3; i++) do_frame(8'd0, 8'h80, rb);
        do_frame(8'd0, 8'hBC, rb);
        chk("y_60", 32'(bus.y_pos_o), 60);
        do_frame(8'd0, 8'hEC, rb);
        chk("top_clamp", 32'(bus.y_pos_o), 50);
        chk("top_rimbalzo", 32'(rb), 1);
        chk("rimbalzo_single", 32'(bus.rimbalzo_o), 0);
        do_frame(8'd0, 8'hEC, rb);
        chk("after_top", 32'(bus.y_pos_o), 70);
        chk("after_top_norb", 32'(rb), 0);

        // Bottom bounce from 970, then enable freeze, then reversed direction kept
        do_reset();
        for (int i = 0; i < 3; i++) do_frame(8'd0, 8'd127, rb);
        do_frame(8'd0, 8'd77, rb);
        chk("y_970", 32'(bus.y_pos_o), 970);
        do_frame(8'd0, 8'd10, rb);
        chk("bottom_clamp", 32'(bus.y_pos_o), 973);
        chk("bottom_rimbalzo", 32'(rb), 1);
        bus.enable_i = 1'b0;
        do_frame(8'd5, 8'd10, rb);
        do_frame(8'd5, 8'd10, rb);
        chk("freeze_x", 32'(bus.x_pos_o), 640);
        chk("freeze_y", 32'(bus.y_pos_o), 973);
        chk("freeze_norb", 32'(rb), 0);
        bus.enable_i = 1'b1;
        do_frame(8'd0, 8'd10, rb);
        chk("dir_kept", 32'(bus.y_pos_o), 963);

        // Async reset while in AGG_X
        do_reset();
        do_frame(8'd10, 8'd0, rb);
        chk("pre_rst_x", 32'(bus.x_pos_o), 650);
        bus.dx_i          = 8'd10;
        bus.frame_start_i = 1'b1;
        tick();
        bus.frame_start_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_x", 32'(bus.x_pos_o), 640);
        chk("async_rst_y", 32'(bus.y_pos_o), 512);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_no_resume", 32'(bus.x_pos_o), 640);

        // Extra frame pulse in AGG_Y must not start a second update
        bus.dx_i          = 8'd10;
        bus.dy_i          = 8'd5;
        bus.frame_start_i = 1'b1;
        tick();
        bus.frame_start_i = 1'b0;
        tick();
        bus.frame_start_i = 1'b1;
        tick();
        bus.frame_start_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("one_update_x", 32'(bus.x_pos_o), 650);
        chk("one_update_y", 32'(bus.y_pos_o), 517);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
